// File: rtl/common_types_pkg.sv
// Shared types and sizing for the RV32M multiplier.
// MULT_RADIX4_EN selects 2 multiplier bits per iteration instead of 1.
package common_types_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

`ifdef MULT_RADIX4_EN
    localparam int BITS_PER_ITER = 2;
`else
    localparam int BITS_PER_ITER = 1;
`endif

    localparam int ITER  = WORD_W / BITS_PER_ITER;
    localparam int CNT_W = $clog2(WORD_W);

endpackage

// File: rtl/mult_unit_if.sv
// Request/result bundle between the EXECUTE pipeline and the multiplier.
interface mult_unit_if;
    import common_types_pkg::*;

    logic              start;
    mult_op_t          op;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              ack;
    logic              flush;
    logic              ready;
    logic [WORD_W-1:0] result;

    modport master (output start, op, a, b, ack, flush, input ready, result);
    modport slave  (input start, op, a, b, ack, flush, output ready, result);

endinterface

// File: rtl/mult_step.sv
// One shift-add iteration: add the selected partial product into the upper half
// of the accumulator and shift right. MULT_RADIX4_EN retires 2 bits per step.
module mult_step
    import common_types_pkg::*;
(
    input  logic [2*WORD_W-1:0] acc,
    input  logic [WORD_W-1:0]   mcand,
    input  logic [WORD_W+1:0]   mcand3,
    input  logic [1:0]          bits,
    output logic [2*WORD_W-1:0] acc_next
);

`ifdef MULT_RADIX4_EN
    logic [WORD_W+1:0] pp;
    logic [WORD_W+1:0] sum;
    logic              unused_bits;

    // Upper half stays below 2^32, so hi + 3a always fits in 34 bits.
    always_comb begin
        unique case (bits)
            2'd0:    pp = '0;
            2'd1:    pp = {2'b00, mcand};
            2'd2:    pp = {1'b0, mcand, 1'b0};
            default: pp = mcand3;
        endcase
        sum      = {2'b00, acc[2*WORD_W-1:WORD_W]} + pp;
        acc_next = {sum, acc[WORD_W-1:2]};
    end

    assign unused_bits = ^acc[1:0];
`else
    logic [WORD_W:0] sum;
    logic            unused_bits;

    assign sum         = {1'b0, acc[2*WORD_W-1:WORD_W]} + (bits[0] ? {1'b0, mcand} : '0);
    assign acc_next    = {sum, acc[WORD_W-1:1]};
    assign unused_bits = ^{mcand3, bits[1], acc[0]};
`endif

endmodule

// File: rtl/mult_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with level request and ack/flush.
// MULT_RADIX4_EN halves the iteration count by retiring 2 multiplier bits per cycle.
module mult_unit
    import common_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mult_unit_if.slave bus
);

    mult_state_t         state;
    mult_op_t            op_r;
    logic [WORD_W-1:0]   mcand;
    logic [WORD_W-1:0]   mplier;
    logic [WORD_W+1:0]   mcand3;
    logic [2*WORD_W-1:0] acc;
    logic [2*WORD_W-1:0] acc_next;
    logic [2*WORD_W-1:0] product;
    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic                ready_r;
    logic [WORD_W-1:0]   result_r;
    logic                sgn_a;
    logic                sgn_b;
    logic [WORD_W-1:0]   mag_a;
    logic [WORD_W-1:0]   mag_b;

    function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v,
                                                    input logic is_neg);
        return is_neg ? -v : v;
    endfunction

    function automatic logic [2*WORD_W-1:0] apply_sign(input logic [2*WORD_W-1:0] p,
                                                       input logic is_neg);
        return is_neg ? -p : p;
    endfunction

    // MUL's low word is sign-independent, so it runs as an unsigned product.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (bus.op)
            MULH: begin
                sgn_a = bus.a[WORD_W-1];
                sgn_b = bus.b[WORD_W-1];
            end
            MULHSU:  sgn_a = bus.a[WORD_W-1];
            default: ;
        endcase
    end

    assign mag_a = magnitude(bus.a, sgn_a);
    assign mag_b = magnitude(bus.b, sgn_b);

    mult_step u_step (
        .acc      (acc),
        .mcand    (mcand),
        .mcand3   (mcand3),
        .bits     (mplier[1:0]),
        .acc_next (acc_next)
    );

    assign product = apply_sign(acc_next, neg);

`ifndef MULT_RADIX4_EN
    assign mcand3 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= MUL;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= '0;
`ifdef MULT_RADIX4_EN
            mcand3   <= '0;
`endif
        end else if (bus.flush) begin
            state   <= IDLE;
            ready_r <= 1'b0;
            acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r   <= bus.op;
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= sgn_a ^ sgn_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
`ifdef MULT_RADIX4_EN
                        mcand3 <= {2'b00, mag_a} + {1'b0, mag_a, 1'b0};
`endif
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> BITS_PER_ITER;
                    cnt    <= cnt + 1'b1;
                    // Last iteration: register the signed-corrected word on DONE entry.
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state    <= DONE;
                        ready_r  <= 1'b1;
                        result_r <= (op_r == MUL) ? product[WORD_W-1:0]
                                                  : product[2*WORD_W-1:WORD_W];
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state   <= IDLE;
                        ready_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.result = result_r;

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative RV32M multiplier in the EXECUTE stage. It consumes MUL/MULH/MULHSU/MULHU operands from the decode-to-execute latch and produces the 32-bit result. Its `ready` output drives the hazard unit's `mult_ready`, and the hazard unit stalls the pipeline while `d2eif_mult && !mult_ready`. It is a multi-cycle state machine with a level request, a registered result, and an explicit consume/flush handshake with the pipeline.

## Interface
Parameters:
- `WORD_W`, 32, operand/result width (from common_types_pkg).

Ports:
- `clk`  in  1  core clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; connected to `d2eif_mult`. Level, held until consumed.
- `op`  in  `mult_op_t` (2)  MUL, MULH, MULHSU, MULHU.
- `a`, `b`  in  WORD_W  rs1/rs2 operand values, post-forwarding.
- `ack`  in  1  pipeline advanced past this instruction; connected to `e2mif_en`.
- `flush`  in  1  squash the in-flight op; connected to `d2eif_flush`.
- `ready`  out  1  `result` is valid for the current request; goes to hazard `mult_ready`.
- `result`  out  WORD_W  registered product word.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset puts the FSM in IDLE with `ready`=0, `result`=0 and all internal registers at 0.
- IDLE:
  - `start && !flush` accepts the request.
  - On accept, the unit latches `op`, |a|, |b| and the result sign, then goes to BUSY with iteration counter 0 and accumulator 0.
- Signedness:
  - `a` is signed for MULH and MULHSU.
  - `b` is signed only for MULH.
  - MUL computes the unsigned low word, since sign does not affect the low 32 bits.
  - Magnitudes are 32-bit unsigned; |-2^31| = 0x80000000.
- BUSY:
  - Each cycle it adds the shifted multiplicand times the low multiplier bit(s) into a 64-bit accumulator.
  - After ITER cycles it goes to DONE.
- DONE entry edge:
  - The 64-bit product is negated if the sign flag is set.
  - `result` is registered: low word for MUL, high word otherwise.
  - `ready` is 1 in DONE only.
- DONE:
  - `ack` returns to IDLE.
  - A `start` still high after the ack belongs to the next instruction; it is accepted from IDLE on the following cycle.
- `flush` in any state forces IDLE next edge, drops `ready`, and discards the accumulator.
- `flush` takes priority over both `ack` and `start`.
- `start`, `op`, `a` and `b` are ignored in BUSY and DONE; operands are captured only at accept.
- `result` holds its last value in IDLE and BUSY. Consumers qualify it with `ready`.

## Timing
- `ready` is registered; there is no combinational path from any input to `ready` or `result`.
- Accept occurs in cycle 0 (IDLE, `start`=1). BUSY spans cycles 1..ITER. `ready`=1 from cycle ITER+1.
- ITER is 32 in the base build and 16 with radix-4.
- Back-to-back mult instructions: the ack edge is followed by one IDLE cycle, then the next accept. Per-op cost is ITER+2 cycles.
- Asynchronous reset mid-BUSY or mid-DONE returns the block to IDLE immediately; no partial result is visible.

## Configuration
- `MULT_RADIX4_EN` defined:
  - The unit retires 2 multiplier bits per cycle by adding 0, a, 2a or 3a.
  - 3a is precomputed at accept into a 34-bit register.
  - ITER = 16, so `ready` rises in cycle 17.
- `MULT_RADIX4_EN` undefined: 1 bit per cycle, ITER = 32, `ready` rises in cycle 33.
- Results are bit-identical in both builds.

## Structure
- common_types_pkg holds:
  - `mult_op_t` (2-bit enum: MUL=0, MULH=1, MULHSU=2, MULHU=3);
  - `WORD_W`;
  - `mult_state_t` (IDLE, BUSY, DONE).
- Sub-module `mult_step`: combinational partial-product add for one iteration, covering both the radix-2 and radix-4 variants.
- The FSM, counter, sign handling and registers stay in `mult_unit`.

## Test plan
- MUL, a=7, b=0xFFFFFFFD (-3): `result`=0xFFFFFFEB. `ready` rises in cycle 33 (cycle 17 with radix-4).
- MULH, a=b=0x80000000: `result`=0x40000000.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF: `result`=0xFFFFFFFF (product 0xFFFFFFFF_00000001).
- MULHU, a=b=0xFFFFFFFF: `result`=0xFFFFFFFE.
- Flush in BUSY cycle 10, `start` held:
  - `ready` stays 0 and the state is IDLE next cycle.
  - The re-accepted op with new operands gives the correct new result at the full latency.
- `ack` in DONE with `start` held high and new operands (MULHU, 3×5):
  - one IDLE cycle occurs with `ready`=0;
  - the new op is accepted;
  - `result`=0x00000000 (high word of 15) with `ready` at the full latency.
  - Also check that `flush` and `ack` asserted together in DONE go to IDLE.
